// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared types and geometry constants for the L1 data cache
//               controller (FSM state encoding, field widths and positions).
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    // Default geometry of the cache and the address space
    localparam int DEF_NUM_LINES  = 16;
    localparam int DEF_LINE_BITS  = 256;
    localparam int DEF_ADDR_W     = 32;
    localparam int WORD_W         = 32;

    // Geometry derived from the defaults
    localparam int WORDS_PER_LINE = DEF_LINE_BITS / WORD_W;
    localparam int OFFSET_W       = $clog2(DEF_LINE_BITS / 8);
    localparam int WSEL_W         = $clog2(WORDS_PER_LINE);
    localparam int INDEX_W        = $clog2(DEF_NUM_LINES);
    localparam int TAG_W          = DEF_ADDR_W - INDEX_W - OFFSET_W;

    // Bit positions of the address fields
    localparam int WSEL_LSB       = 2;
    localparam int INDEX_LSB      = OFFSET_W;
    localparam int TAG_LSB        = OFFSET_W + INDEX_W;

    // Controller states; IDLE serves hits, the other two own the memory port
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
// Module      : dcache_array
// Description : Storage for the direct-mapped cache: per-line valid, dirty,
//               tag and data. One combinational read port, one full-line
//               write port (refill) and one word write port (store hit).
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    // read port
    input  logic [$clog2(NUM_LINES)-1:0]              rd_index_i,
    output logic                                      rd_valid_o,
    output logic                                      rd_dirty_o,
    output logic [ADDR_W-$clog2(NUM_LINES)-$clog2(LINE_BITS/8)-1:0] rd_tag_o,
    output logic [LINE_BITS-1:0]                      rd_line_o,
    // line write port: installs a fresh clean line
    input  logic                                      line_we_i,
    input  logic [$clog2(NUM_LINES)-1:0]              line_index_i,
    input  logic [ADDR_W-$clog2(NUM_LINES)-$clog2(LINE_BITS/8)-1:0] line_tag_i,
    input  logic [LINE_BITS-1:0]                      line_data_i,
    // word write port: store hit, marks the line dirty
    input  logic                                      word_we_i,
    input  logic [$clog2(NUM_LINES)-1:0]              word_index_i,
    input  logic [$clog2(LINE_BITS/WORD_W)-1:0]       word_sel_i,
    input  logic [WORD_W-1:0]                         word_data_i
);

    localparam int C_INDEX_W  = $clog2(NUM_LINES);
    localparam int C_OFFSET_W = $clog2(LINE_BITS / 8);
    localparam int C_TAG_W    = ADDR_W - C_INDEX_W - C_OFFSET_W;

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [C_TAG_W-1:0]   tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_dirty_o = dirty_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_line_o  = data_q[rd_index_i];

    // Next valid/dirty bits: refill makes a line valid and clean, store dirties it
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (line_we_i) begin
            valid_d[line_index_i] = 1'b1;
            dirty_d[line_index_i] = 1'b0;
        end
        if (word_we_i) begin
            dirty_d[word_index_i] = 1'b1;
        end
    end

    // Valid/dirty flags are the only state that reset must clear
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data contents are meaningless until valid, so they carry no reset
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_q[line_index_i]  <= line_tag_i;
            data_q[line_index_i] <= line_data_i;
        end
        if (word_we_i) begin
            data_q[word_index_i][int'(word_sel_i)*WORD_W +: WORD_W] <= word_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller
// Description : Direct-mapped, write-back, write-allocate L1 data cache.
//               Hits complete with no wait cycles; misses stall the pipeline
//               while a dirty victim is written back and the line refilled.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // MEM-stage side
    input  logic                 cpu_req_i,
    input  logic                 cpu_write_i,
    input  logic [ADDR_W-1:0]    cpu_addr_i,
    input  logic [WORD_W-1:0]    cpu_wdata_i,
    output logic [WORD_W-1:0]    cpu_rdata_o,
    output logic                 cpu_stall_o,
    // memory side
    output logic                 mem_req_o,
    output logic                 mem_write_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    input  logic                 mem_ack_i
);

    localparam int C_WORDS    = LINE_BITS / WORD_W;
    localparam int C_OFFSET_W = $clog2(LINE_BITS / 8);
    localparam int C_WSEL_W   = $clog2(C_WORDS);
    localparam int C_INDEX_W  = $clog2(NUM_LINES);
    localparam int C_TAG_W    = ADDR_W - C_INDEX_W - C_OFFSET_W;

    // Address fields of the current CPU access
    logic [C_TAG_W-1:0]   w_cpu_tag;
    logic [C_INDEX_W-1:0] w_cpu_index;
    logic [C_WSEL_W-1:0]  w_cpu_wsel;
    logic [1:0]           w_unused_byte;

    // Array read port and derived hit information
    logic                 w_rd_valid;
    logic                 w_rd_dirty;
    logic [C_TAG_W-1:0]   w_rd_tag;
    logic [LINE_BITS-1:0] w_rd_line;
    logic [WORD_W-1:0]    w_rd_word;
    logic                 w_hit;
    logic                 w_idle;
    logic                 w_line_we;
    logic                 w_word_we;

    // FSM and registered memory-port outputs
    state_e               state_q,      state_d;
    logic                 mem_req_q,    mem_req_d;
    logic                 mem_write_q,  mem_write_d;
    logic [ADDR_W-1:0]    mem_addr_q,   mem_addr_d;
    logic [LINE_BITS-1:0] mem_wdata_q,  mem_wdata_d;
    logic [C_TAG_W-1:0]   miss_tag_q,   miss_tag_d;
    logic [C_INDEX_W-1:0] miss_index_q, miss_index_d;

    assign w_cpu_tag     = cpu_addr_i[ADDR_W-1 -: C_TAG_W];
    assign w_cpu_index   = cpu_addr_i[C_OFFSET_W +: C_INDEX_W];
    assign w_cpu_wsel    = cpu_addr_i[2 +: C_WSEL_W];
    // Accesses are word aligned, so the byte-within-word bits carry no information
    assign w_unused_byte = cpu_addr_i[1:0];

    assign w_rd_word = w_rd_line[int'(w_cpu_wsel)*WORD_W +: WORD_W];
    assign w_hit     = cpu_req_i & w_rd_valid & (w_rd_tag == w_cpu_tag);
    assign w_idle    = (state_q == S_IDLE);

    // A store is only performed once the line is resident and the FSM is idle,
    // which also makes a store miss finish as an ordinary store hit.
    assign w_word_we = w_idle & w_hit & cpu_write_i;
    // Refill data is installed with the ack; the miss address was latched so
    // the fill completes even if the pipeline withdraws its request.
    assign w_line_we = (state_q == S_ALLOCATE) & mem_ack_i;

    assign cpu_stall_o = cpu_req_i & (~w_idle | ~w_hit);
    assign cpu_rdata_o = (w_idle & w_hit & ~cpu_write_i) ? w_rd_word : '0;

    assign mem_req_o   = mem_req_q;
    assign mem_write_o = mem_write_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    dcache_array #(
        .NUM_LINES (NUM_LINES),
        .LINE_BITS (LINE_BITS),
        .ADDR_W    (ADDR_W)
    ) u_array (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rd_index_i   (w_cpu_index),
        .rd_valid_o   (w_rd_valid),
        .rd_dirty_o   (w_rd_dirty),
        .rd_tag_o     (w_rd_tag),
        .rd_line_o    (w_rd_line),
        .line_we_i    (w_line_we),
        .line_index_i (miss_index_q),
        .line_tag_i   (miss_tag_q),
        .line_data_i  (mem_rdata_i),
        .word_we_i    (w_word_we),
        .word_index_i (w_cpu_index),
        .word_sel_i   (w_cpu_wsel),
        .word_data_i  (cpu_wdata_i)
    );

    // Next state and next memory-port values; outputs are set on entering a state
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        miss_tag_d   = miss_tag_q;
        miss_index_d = miss_index_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_i && !w_hit) begin
                    miss_tag_d   = w_cpu_tag;
                    miss_index_d = w_cpu_index;
                    mem_req_d    = 1'b1;
                    if (w_rd_valid && w_rd_dirty) begin
                        state_d     = S_WRITEBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {w_rd_tag, w_cpu_index, {C_OFFSET_W{1'b0}}};
                        mem_wdata_d = w_rd_line;
                    end else begin
                        state_d     = S_ALLOCATE;
                        mem_write_d = 1'b0;
                        mem_addr_d  = {w_cpu_tag, w_cpu_index, {C_OFFSET_W{1'b0}}};
                        mem_wdata_d = '0;
                    end
                end
            end
            S_WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d     = S_ALLOCATE;
                    mem_write_d = 1'b0;
                    mem_addr_d  = {miss_tag_q, miss_index_q, {C_OFFSET_W{1'b0}}};
                    mem_wdata_d = '0;
                end
            end
            S_ALLOCATE: begin
                if (mem_ack_i) begin
                    state_d     = S_IDLE;
                    mem_req_d   = 1'b0;
                    mem_write_d = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                mem_req_d   = 1'b0;
                mem_write_d = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
            end
        endcase
    end

    // Controller FSM with registered memory-port outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            mem_req_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            miss_tag_q   <= '0;
            miss_index_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            miss_tag_q   <= miss_tag_d;
            miss_index_q <= miss_index_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_controller
// Description : Self-checking bench for dcache_controller: directed vector
//               table, multi-cycle corner sequences and randomized accesses
//               against a transaction-level cache + memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] mem_rdata_i;
    logic         mem_ack_i;

    int n_checks = 0;
    int n_errors = 0;

    dcache_controller dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_write_i (cpu_write_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic         m_valid [16];
    logic         m_dirty [16];
    logic [22:0]  m_tag   [16];
    logic [255:0] m_line  [16];
    logic [31:0]  mem_mod [logic [31:0]];

    // Unwritten memory word at byte address a reads as a ^ A5A5_0000
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_mod.exists(a)) return mem_mod[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = mem_rd(la + 32'(i*4));
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One CPU access with a responding memory; checks memory-port traffic
    // against the model and returns observed and modelled stalls/rdata.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int lat_wb, input int lat_fill,
                          output int act_stalls, output logic [31:0] act_rdata,
                          output int mdl_stalls, output logic [31:0] mdl_rdata);
        logic [3:0]   idx;
        logic [22:0]  tg;
        logic [2:0]   w;
        logic         hit, wb;
        logic [31:0]  wb_addr, fill_addr;
        logic [255:0] wb_line, fill_line;
        int           phase, rc, st;
        bit           done;
        idx = addr[8:5];
        tg  = addr[31:9];
        w   = addr[4:2];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        wb  = !hit && m_valid[idx] && m_dirty[idx];
        wb_addr   = {m_tag[idx], idx, 5'b0};
        wb_line   = m_line[idx];
        fill_addr = {addr[31:5], 5'b0};
        if (wb) for (int i = 0; i < 8; i++) mem_mod[wb_addr + 32'(i*4)] = wb_line[i*32 +: 32];
        fill_line = mem_line(fill_addr);
        if (!hit) begin
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            m_line[idx]  = fill_line;
        end
        if (wr) begin
            m_line[idx][int'(w)*32 +: 32] = wd;
            m_dirty[idx] = 1'b1;
        end
        mdl_rdata  = wr ? 32'h0 : m_line[idx][int'(w)*32 +: 32];
        mdl_stalls = hit ? 0 : ((wb ? lat_wb : 0) + lat_fill + 1);

        cpu_req_i   = 1'b1;
        cpu_write_i = wr;
        cpu_addr_i  = addr;
        cpu_wdata_i = wd;
        phase = wb ? 0 : 1;
        rc = 0;
        st = 0;
        done = 1'b0;
        act_rdata = 32'h0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (!cpu_stall_o) begin
                act_rdata = cpu_rdata_o;
                done = 1'b1;
            end else begin
                st++;
                if (mem_req_o) begin
                    rc++;
                    if (rc == 1) begin
                        check("mem_write", mem_write_o, (phase == 0));
                        check("mem_addr", mem_addr_o, (phase == 0) ? wb_addr : fill_addr);
                        if (phase == 0) check("mem_wdata", mem_wdata_o, wb_line);
                    end
                    if (rc == ((phase == 0) ? lat_wb : lat_fill)) begin
                        mem_ack_i = 1'b1;
                        if (phase == 1) mem_rdata_i = fill_line;
                        phase++;
                        rc = 0;
                    end
                end
                @(posedge clk);
                #1;
                mem_ack_i = 1'b0;
            end
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL access_timeout: addr=%0h still stalled after 100 cycles", addr);
        end
        act_stalls = st;
        @(posedge clk);
        #1;
        cpu_req_i = 1'b0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat_wb;
        int          lat_fill;
        int          exp_stalls;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    int          a_st, m_st;
    logic [31:0] a_rd, m_rd;
    logic [31:0] r_addr;
    logic        r_wr;

    initial begin
        vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0,          1, 5, 6, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 32'h0000_0104, 32'h1234_5678,  1, 1, 0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0104, 32'h0,          1, 1, 0, 32'h1234_5678};
        vecs[3]  = '{1'b0, 32'h0000_2104, 32'h0,          3, 2, 6, 32'hA5A5_2104};
        vecs[4]  = '{1'b0, 32'h0000_0104, 32'h0,          1, 1, 2, 32'h1234_5678};
        vecs[5]  = '{1'b0, 32'h0000_2108, 32'h0,          1, 4, 5, 32'hA5A5_2108};
        vecs[6]  = '{1'b1, 32'h0000_3000, 32'hCAFE_F00D,  1, 1, 2, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_3004, 32'h0,          1, 1, 0, 32'hA5A5_3004};
        vecs[8]  = '{1'b0, 32'h0000_3000, 32'h0,          1, 1, 0, 32'hCAFE_F00D};
        vecs[9]  = '{1'b0, 32'h0000_1000, 32'h0,          1, 1, 3, 32'hA5A5_1000};
        vecs[10] = '{1'b0, 32'h0000_3000, 32'h0,          1, 2, 3, 32'hCAFE_F00D};

        model_reset();
        mem_mod[32'h0000_0100] = 32'hDEAD_BEEF;

        rst_i = 1'b0;
        cpu_req_i = 1'b0;
        cpu_write_i = 1'b0;
        cpu_addr_i = 32'h0;
        cpu_wdata_i = 32'h0;
        mem_rdata_i = '0;
        mem_ack_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_write", mem_write_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_wdata", mem_wdata_o, 0);
        check("rst_stall", cpu_stall_o, 0);
        check("rst_rdata", cpu_rdata_o, 0);
        @(posedge clk);
        #1;

        // directed table
        for (int i = 0; i < 11; i++) begin
            access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lat_wb, vecs[i].lat_fill,
                   a_st, a_rd, m_st, m_rd);
            check($sformatf("vec%0d_stalls", i), a_st, vecs[i].exp_stalls);
            check($sformatf("vec%0d_rdata", i), a_rd, vecs[i].exp_rdata);
        end

        // stray acks while idle with no request
        for (int i = 0; i < 3; i++) begin
            mem_ack_i = 1'b1;
            @(posedge clk);
            #1;
            mem_ack_i = 1'b0;
            @(negedge clk);
            check("stray_ack_req", mem_req_o, 0);
            check("stray_ack_stall", cpu_stall_o, 0);
        end

        // 16 back-to-back hits with stray acks interleaved
        for (int i = 0; i < 16; i++) begin
            cpu_req_i   = 1'b1;
            cpu_write_i = 1'b0;
            cpu_addr_i  = 32'h3000 + 32'((i % 8) * 4);
            mem_ack_i   = i[0];
            @(negedge clk);
            check($sformatf("hit%0d_stall", i), cpu_stall_o, 0);
            check($sformatf("hit%0d_rdata", i), cpu_rdata_o, m_line[0][(i % 8)*32 +: 32]);
            check($sformatf("hit%0d_req", i), mem_req_o, 0);
            @(posedge clk);
            #1;
        end
        mem_ack_i = 1'b0;
        cpu_req_i = 1'b0;

        // request withdrawn mid-miss: fill completes, store is not performed
        cpu_req_i   = 1'b1;
        cpu_write_i = 1'b1;
        cpu_addr_i  = 32'h5000;
        cpu_wdata_i = 32'h0BAD_F00D;
        @(negedge clk);
        check("drop_stall0", cpu_stall_o, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("drop_req1", mem_req_o, 1);
        check("drop_addr1", mem_addr_o, 32'h5000);
        @(posedge clk);
        #1;
        cpu_req_i = 1'b0;
        @(negedge clk);
        check("drop_req_held", mem_req_o, 1);
        check("drop_stall_low", cpu_stall_o, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_line(32'h5000);
        @(posedge clk);
        #1;
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("drop_req_done", mem_req_o, 0);
        m_valid[0] = 1'b1;
        m_dirty[0] = 1'b0;
        m_tag[0]   = 23'(32'h5000 >> 9);
        m_line[0]  = mem_line(32'h5000);
        @(posedge clk);
        #1;
        access(1'b0, 32'h5000, 32'h0, 1, 1, a_st, a_rd, m_st, m_rd);
        check("drop_load_stalls", a_st, 0);
        check("drop_load_rdata", a_rd, 32'hA5A5_5000);

        // reset asserted during ALLOCATE, with an ack arriving alongside
        cpu_req_i   = 1'b1;
        cpu_write_i = 1'b0;
        cpu_addr_i  = 32'h6000;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rstmid_req", mem_req_o, 1);
        @(posedge clk);
        #1;
        rst_i       = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_line(32'h6000);
        cpu_req_i   = 1'b0;
        #1;
        check("rstmid_req_drop", mem_req_o, 0);
        check("rstmid_addr_zero", mem_addr_o, 0);
        @(posedge clk);
        #1;
        mem_ack_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        model_reset();
        mem_ack_i = 1'b1;
        @(posedge clk);
        #1;
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("late_ack_req", mem_req_o, 0);
        @(posedge clk);
        #1;
        access(1'b0, 32'h6000, 32'h0, 1, 2, a_st, a_rd, m_st, m_rd);
        check("post_rst_6000_stalls", a_st, 3);
        check("post_rst_6000_rdata", a_rd, 32'hA5A5_6000);
        access(1'b0, 32'h0104, 32'h0, 1, 1, a_st, a_rd, m_st, m_rd);
        check("post_rst_104_stalls", a_st, 2);
        check("post_rst_104_rdata", a_rd, 32'h1234_5678);

        // randomized accesses against the model
        for (int n = 0; n < 250; n++) begin
            r_addr = {21'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                      3'($urandom_range(0, 7)), 2'b00};
            r_wr   = 1'($urandom_range(0, 1));
            access(r_wr, r_addr, $urandom, int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                   a_st, a_rd, m_st, m_rd);
            check($sformatf("rnd%0d_stalls", n), a_st, m_st);
            check($sformatf("rnd%0d_rdata", n), a_rd, m_rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate L1 data cache between the pipeline MEM stage and a multi-cycle off-chip data memory. The MEM stage presents word loads/stores; hits complete with zero wait cycles, misses raise a stall that freezes the whole pipeline while the controller evicts a dirty line and refills the target line over a req/ack memory port.

## Interface
- NUM_LINES, 16: cache lines; power of two.
- LINE_BITS, 256: line size (32 bytes, 8 words).
- ADDR_W, 32: byte address width.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- cpu_req_i  input  1  MEM stage access valid (MemRead or MemWrite).
- cpu_write_i  input  1  1 = store, 0 = load.
- cpu_addr_i  input  ADDR_W  byte address, word-aligned.
- cpu_wdata_i  input  32  store data.
- cpu_rdata_o  output  32  load data, valid when cpu_req_i & !cpu_write_i & !cpu_stall_o.
- cpu_stall_o  output  1  freeze PC and all pipeline registers.
- mem_req_o  output  1  memory request, held until mem_ack_i.
- mem_write_o  output  1  1 = line write-back, 0 = line fetch.
- mem_addr_o  output  ADDR_W  line-aligned address (low 5 bits zero).
- mem_wdata_o  output  LINE_BITS  evicted line.
- mem_rdata_i  input  LINE_BITS  fetched line, valid with mem_ack_i.
- mem_ack_i  input  1  single-cycle completion pulse.

## Operation
- Address split: offset [4:0], word select [4:2], index [8:5], tag [31:9] (23 bits) at defaults.
- Per line: valid, dirty, tag, data. Reset clears all valid and dirty; data/tag contents don't-care.
- Hit = cpu_req_i & valid[index] & tag match. Combinational.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE: hit load -> cpu_rdata_o = selected word. Hit store -> word written, dirty set at edge. Miss with dirty victim -> WRITEBACK; miss with clean/invalid victim -> ALLOCATE.
- WRITEBACK: mem_req_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_wdata_o=victim line. On mem_ack_i -> ALLOCATE.
- ALLOCATE: mem_req_o=1, mem_write_o=0, mem_addr_o={cpu tag, index, 5'b0}. On mem_ack_i: line <- mem_rdata_i, tag <- cpu tag, valid=1, dirty=0; -> IDLE.
- Back in IDLE the held request hits; store-miss completes as store-hit (dirty=1).
- cpu_stall_o = cpu_req_i & (state != IDLE | !hit). Pipeline must hold cpu_* stable while stalled.
- mem_* outputs Moore (decoded from state); mem_wdata_o and mem_addr_o zero in IDLE.

## Timing
- Reset values: state IDLE, mem_req_o=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0; cpu_stall_o=0 and cpu_rdata_o=0 while cpu_req_i=0.
- Hit: 0 wait cycles; store visible to load in next cycle.
- Clean miss detected cycle 0; mem_req_o high from cycle 1; ack in cycle k (k>=1) -> stall low in cycle k+1.
- Dirty miss: write-back ack in cycle j -> fetch request from cycle j+1; stall low the cycle after fetch ack.
- mem_ack_i in IDLE, or with cpu_req_i low, ignored.
- mem_ack_i may arrive in the first cycle of mem_req_o.
- cpu_req_i dropping mid-miss: transaction still completes; no store performed.
- Reset mid-miss: FSM to IDLE, req dropped, all lines invalid; late ack ignored.
- cpu_rdata_o = 0 whenever not a load hit.

## Structure
- Package dcache_pkg: state enum, OFFSET_W/INDEX_W/TAG_W and WORDS_PER_LINE derived from parameters, field-extraction constants.
- Sub-module dcache_array: valid/dirty/tag/data storage, async-reset valid/dirty, single read port (combinational), one line-write and one word-write port.

## Test plan
- Reset, load 0x0000_0100 (memory word 0xDEADBEEF, ack after 5 cycles) -> mem_req_o with addr 0x100, write=0 from cycle 1; stall 6 cycles; rdata 0xDEADBEEF cycle 7.
- Store 0x1234_5678 to 0x104 after above, then load 0x104 -> no stall either access; rdata 0x12345678; dirty set.
- Load 0x2104 (same index 8, new tag) -> WRITEBACK to 0x100 with word 1 = 0x12345678, then ALLOCATE 0x2100; no write-back on second eviction of a clean line.
- Store miss to 0x3000 with ack latency 1 -> one fetch, line written then word stored; later eviction writes back stored value.
- Assert rst_i low during ALLOCATE then ack -> mem_req_o drops immediately; ack ignored; next load to same address misses.
- Stray mem_ack_i pulses in IDLE and 16 sequential hits -> no state change, stall never asserted.
